// File: rtl/wbupsizer.sv
// Pipelined Wishbone width upsizer: each narrow DW beat becomes one WIDE_DW beat.
// A lane FIFO records the narrow lane of every outstanding request to steer read returns.
module wbupsizer #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int WIDE_DW = 128,
  parameter int LGFIFO  = 5
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_wb_cyc,
  input  logic                          i_wb_stb,
  input  logic                          i_wb_we,
  input  logic [AW-1:0]                 i_wb_addr,
  input  logic [DW-1:0]                 i_wb_data,
  input  logic [DW/8-1:0]               i_wb_sel,
  output logic                          o_wb_stall,
  output logic                          o_wb_ack,
  output logic [DW-1:0]                 o_wb_data,
  output logic                          o_wb_err,
  output logic                          o_dwb_cyc,
  output logic                          o_dwb_stb,
  output logic                          o_dwb_we,
  output logic [AW-$clog2(WIDE_DW/DW)-1:0] o_dwb_addr,
  output logic [WIDE_DW-1:0]            o_dwb_data,
  output logic [WIDE_DW/8-1:0]          o_dwb_sel,
  input  logic                          i_dwb_stall,
  input  logic                          i_dwb_ack,
  input  logic [WIDE_DW-1:0]            i_dwb_data,
  input  logic                          i_dwb_err
);
  localparam int R     = WIDE_DW / DW;
  localparam int LS    = $clog2(R);
  localparam int SW    = DW / 8;
  localparam int WSW   = WIDE_DW / 8;
  localparam int DEPTH = 1 << LGFIFO;

  logic                r_cyc, r_stb, r_we;
  logic [AW-LS-1:0]    r_addr;
  logic [WIDE_DW-1:0]  r_data;
  logic [WSW-1:0]      r_sel;
  logic                r_ack, r_err;
  logic [DW-1:0]       r_rdata;
  logic [LS-1:0]       r_fifo [DEPTH];
  logic [LGFIFO-1:0]   r_wr_ptr, r_rd_ptr;
  logic [LGFIFO:0]     r_count;

  logic                w_full, w_stall, w_accept, w_flush, w_push, w_pop;
  logic [LS-1:0]       w_lane, w_pop_lane;
  logic [WSW-1:0]      w_sel;
  logic [DW-1:0]       w_rdata;

  assign w_lane     = i_wb_addr[LS-1:0];
  assign w_full     = (r_count == (LGFIFO+1)'(DEPTH));
  assign w_stall    = (r_stb && i_dwb_stall) || w_full || !i_wb_cyc;
  assign w_accept   = i_wb_stb && !w_stall;
  // A bus error or a dropped narrow cycle abandons everything in flight.
  assign w_flush    = !i_wb_cyc || (i_dwb_err && r_cyc);
  assign w_push     = w_accept && !w_flush;
  assign w_pop      = i_dwb_ack && r_cyc && (r_count != '0) && !w_flush;
  assign w_pop_lane = r_fifo[r_rd_ptr];

  always_comb begin
    w_sel   = '0;
    w_rdata = '0;
    for (int k = 0; k < R; k++) begin
      if (int'(w_lane) == k)
        w_sel[k*SW +: SW] = i_wb_sel;
      if (int'(w_pop_lane) == k)
        w_rdata = i_dwb_data[k*DW +: DW];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_flush) begin
      r_cyc <= 1'b0;
      r_stb <= 1'b0;
    end else if (w_accept) begin
      r_cyc <= 1'b1;
      r_stb <= 1'b1;
    end else if (!i_dwb_stall) begin
      r_stb <= 1'b0;
    end
  end

  // Request fields only load on accept, so they hold while the wide slave stalls.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_we   <= i_wb_we;
      r_addr <= i_wb_addr[AW-1:LS];
      r_data <= {R{i_wb_data}};
      r_sel  <= w_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= r_wr_ptr + LGFIFO'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + LGFIFO'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (LGFIFO+1)'(1);
        2'b01:   r_count <= r_count - (LGFIFO+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push)
      r_fifo[r_wr_ptr] <= w_lane;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_ack <= w_pop;
      r_err <= i_dwb_err && r_cyc && i_wb_cyc;
    end
    if (w_pop)
      r_rdata <= w_rdata;
  end

  assign o_wb_stall = w_stall;
  assign o_wb_ack   = r_ack;
  assign o_wb_err   = r_err;
  assign o_wb_data  = r_rdata;
  assign o_dwb_cyc  = r_cyc;
  assign o_dwb_stb  = r_stb;
  assign o_dwb_we   = r_we;
  assign o_dwb_addr = r_addr;
  assign o_dwb_data = r_data;
  assign o_dwb_sel  = r_sel;

endmodule

// File: tb/tb_wbupsizer.sv
// Bench for wbupsizer: vector table, directed corner sequences, and a random
// phase checked against a transaction-level model of the upsizer.
module tb_wbupsizer;
  localparam int AW = 26, DW = 32, WDW = 128, LGFIFO = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_reset_n, i_wb_cyc, i_wb_stb, i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [3:0]      i_wb_sel;
  logic            o_wb_stall, o_wb_ack, o_wb_err;
  logic [DW-1:0]   o_wb_data;
  logic            o_dwb_cyc, o_dwb_stb, o_dwb_we;
  logic [23:0]     o_dwb_addr;
  logic [WDW-1:0]  o_dwb_data;
  logic [15:0]     o_dwb_sel;
  logic            i_dwb_stall, i_dwb_ack, i_dwb_err;
  logic [WDW-1:0]  i_dwb_data;

  wbupsizer #(.AW(AW), .DW(DW), .WIDE_DW(WDW), .LGFIFO(LGFIFO)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n),
    .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
    .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
    .o_wb_stall(o_wb_stall), .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
    .o_wb_err(o_wb_err),
    .o_dwb_cyc(o_dwb_cyc), .o_dwb_stb(o_dwb_stb), .o_dwb_we(o_dwb_we),
    .o_dwb_addr(o_dwb_addr), .o_dwb_data(o_dwb_data), .o_dwb_sel(o_dwb_sel),
    .i_dwb_stall(i_dwb_stall), .i_dwb_ack(i_dwb_ack), .i_dwb_data(i_dwb_data),
    .i_dwb_err(i_dwb_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams reads until the upsizer stalls; returns how many were accepted.
  task automatic fill(output int n);
    n = 0;
    i_wb_stb = 1'b1;
    i_wb_we  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      i_wb_addr = AW'($urandom);
      #1;
      if (!o_wb_stall) n++;
      tick();
    end
    i_wb_stb = 1'b0;
    #1;
    chk("fill_stall", o_wb_stall, 1'b1);
  endtask

  typedef struct {
    logic [AW-1:0]  addr;
    logic [31:0]    data;
    logic [3:0]     sel;
    logic           we;
    logic [127:0]   rwide;
    logic [23:0]    e_addr;
    logic [15:0]    e_sel;
    logic [127:0]   e_wdata;
    logic [31:0]    e_rdata;
  } vec_t;

  vec_t vecs[5];

  typedef struct packed {
    logic         we;
    logic [23:0]  addr;
    logic [127:0] data;
    logic [15:0]  sel;
  } wreq_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    wreq_t exp_req;
    bit exp_stb, exp_ack, m_stall;
    logic [31:0] exp_rdata;
    logic [1:0] lane_q[$];
    logic [1:0] lane;
    int pending;

    vecs[0] = '{26'h0000003, 32'hDEADBEEF, 4'hF, 1'b1,
                128'h0,
                24'h000000, 16'hF000, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 32'h0};
    vecs[1] = '{26'h0000005, 32'h12345678, 4'h3, 1'b0,
                128'h44444444_33333333_22222222_11111111,
                24'h000001, 16'h0030, 128'h12345678_12345678_12345678_12345678, 32'h22222222};
    vecs[2] = '{26'h3FFFFFE, 32'hA5A50F0F, 4'h9, 1'b0,
                128'hCAFEF00D_0BADC0DE_FEEDFACE_01234567,
                24'hFFFFFF, 16'h0900, 128'hA5A50F0F_A5A50F0F_A5A50F0F_A5A50F0F, 32'h0BADC0DE};
    vecs[3] = '{26'h0000008, 32'h0000FFFF, 4'h1, 1'b1,
                128'h89ABCDEF_76543210_FFFFFFFF_A0B1C2D3,
                24'h000002, 16'h0001, 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF, 32'hA0B1C2D3};
    vecs[4] = '{26'h2AAAAA9, 32'h00000000, 4'hC, 1'b0,
                128'h00000004_00000003_00000002_00000001,
                24'hAAAAAA, 16'h00C0, 128'h0, 32'h00000002};

    i_reset_n = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    i_wb_addr = '0; i_wb_data = '0; i_wb_sel = '0;
    i_dwb_stall = 1'b0; i_dwb_ack = 1'b0; i_dwb_data = '0; i_dwb_err = 1'b0;
    tick();
    tick();
    chk("rst_ack", o_wb_ack, 1'b0);
    chk("rst_err", o_wb_err, 1'b0);
    chk("rst_dcyc", o_dwb_cyc, 1'b0);
    chk("rst_dstb", o_dwb_stb, 1'b0);
    i_reset_n = 1'b1;
    tick();
    i_wb_cyc = 1'b1;

    // Single transactions: lane mapping, 1-cycle request and response latency.
    for (int i = 0; i < 5; i++) begin
      i_wb_stb = 1'b1; i_wb_addr = vecs[i].addr; i_wb_data = vecs[i].data;
      i_wb_sel = vecs[i].sel; i_wb_we = vecs[i].we;
      #1;
      chk("tbl_stall", o_wb_stall, 1'b0);
      tick();
      i_wb_stb = 1'b0;
      chk("tbl_dstb", o_dwb_stb, 1'b1);
      chk("tbl_dcyc", o_dwb_cyc, 1'b1);
      chk("tbl_daddr", o_dwb_addr, vecs[i].e_addr);
      chk("tbl_dsel", o_dwb_sel, vecs[i].e_sel);
      chk("tbl_ddata", o_dwb_data, vecs[i].e_wdata);
      chk("tbl_dwe", o_dwb_we, vecs[i].we);
      i_dwb_ack = 1'b1; i_dwb_data = vecs[i].rwide;
      tick();
      i_dwb_ack = 1'b0;
      chk("tbl_ack", o_wb_ack, 1'b1);
      chk("tbl_rdata", o_wb_data, vecs[i].e_rdata);
      chk("tbl_dstb_drop", o_dwb_stb, 1'b0);
      tick();
      chk("tbl_ack_pulse", o_wb_ack, 1'b0);
    end

    // Four back-to-back reads, lanes 0..3 returned in order.
    i_wb_sel = 4'hF; i_wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_wb_stb = 1'b1; i_wb_addr = AW'(4 + i);
      #1;
      chk("burst_stall", o_wb_stall, 1'b0);
      tick();
    end
    i_wb_stb = 1'b0;
    i_dwb_ack = 1'b1; i_dwb_data = 128'h33333333_22222222_11111111_00000000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("burst_ack", o_wb_ack, 1'b1);
      chk("burst_data", o_wb_data, 32'h11111111 * i);
    end
    i_dwb_ack = 1'b0;
    tick();
    chk("burst_ack_end", o_wb_ack, 1'b0);

    // Wide stall holds the presented request for five cycles.
    i_wb_stb = 1'b1; i_wb_addr = 26'h10;
    tick();
    i_wb_addr = 26'h11; i_dwb_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_nstall", o_wb_stall, 1'b1);
      tick();
      chk("stall_dstb", o_dwb_stb, 1'b1);
      chk("stall_daddr", o_dwb_addr, 24'h4);
      chk("stall_dsel", o_dwb_sel, 16'h000F);
    end
    i_dwb_stall = 1'b0;
    #1;
    chk("stall_release", o_wb_stall, 1'b0);
    tick();
    i_wb_stb = 1'b0;
    chk("stall_b_addr", o_dwb_addr, 24'h4);
    chk("stall_b_sel", o_dwb_sel, 16'h00F0);
    tick();
    chk("stall_b_drop", o_dwb_stb, 1'b0);
    i_dwb_ack = 1'b1; i_dwb_data = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    tick();
    chk("stall_ack_a", o_wb_ack, 1'b1);
    chk("stall_data_a", o_wb_data, 32'hAAAAAAAA);
    tick();
    chk("stall_ack_b", o_wb_ack, 1'b1);
    chk("stall_data_b", o_wb_data, 32'hBBBBBBBB);
    tick();
    chk("empty_ack_ignored", o_wb_ack, 1'b0);
    i_dwb_ack = 1'b0;

    // Error on the second of three outstanding reads.
    i_wb_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wb_addr = AW'(32 + i);
      tick();
    end
    i_wb_stb = 1'b0;
    i_dwb_ack = 1'b1; i_dwb_data = 128'h0C0C0C0C_0B0B0B0B_0A0A0A0A_09090909;
    tick();
    i_dwb_ack = 1'b0; i_dwb_err = 1'b1;
    chk("err_first_ack", o_wb_ack, 1'b1);
    chk("err_first_data", o_wb_data, 32'h09090909);
    tick();
    i_dwb_err = 1'b0;
    chk("err_pulse", o_wb_err, 1'b1);
    chk("err_no_ack", o_wb_ack, 1'b0);
    chk("err_dcyc", o_dwb_cyc, 1'b0);
    chk("err_dstb", o_dwb_stb, 1'b0);
    i_dwb_ack = 1'b1;
    tick();
    i_dwb_ack = 1'b0;
    chk("err_single", o_wb_err, 1'b0);
    chk("err_late_ack", o_wb_ack, 1'b0);

    // Lane FIFO fills at 32; one ack releases the stall on the next cycle.
    fill(n);
    chk("full_count", n, 32);
    i_dwb_ack = 1'b1;
    #1;
    chk("full_stall_hold", o_wb_stall, 1'b1);
    tick();
    i_dwb_ack = 1'b0;
    #1;
    chk("full_release", o_wb_stall, 1'b0);
    i_dwb_ack = 1'b1;
    for (int i = 0; i < 31; i++) tick();
    i_dwb_ack = 1'b0;
    tick();

    // Reset with three requests in flight.
    i_wb_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_wb_addr = AW'(64 + i);
      tick();
    end
    i_wb_stb = 1'b0;
    i_reset_n = 1'b0; i_dwb_ack = 1'b1;
    tick();
    chk("mrst_ack", o_wb_ack, 1'b0);
    chk("mrst_err", o_wb_err, 1'b0);
    chk("mrst_dcyc", o_dwb_cyc, 1'b0);
    chk("mrst_dstb", o_dwb_stb, 1'b0);
    i_reset_n = 1'b1;
    tick();
    i_dwb_ack = 1'b0;
    chk("mrst_ack_after", o_wb_ack, 1'b0);
    fill(n);
    chk("mrst_count", n, 32);

    // Narrow cycle drop with the FIFO full, ack in the same cycle.
    i_wb_cyc = 1'b0; i_dwb_ack = 1'b1;
    tick();
    chk("cycdrop_dcyc", o_dwb_cyc, 1'b0);
    chk("cycdrop_dstb", o_dwb_stb, 1'b0);
    chk("cycdrop_ack", o_wb_ack, 1'b0);
    i_wb_cyc = 1'b1;
    tick();
    i_dwb_ack = 1'b0;
    chk("cycdrop_late_ack", o_wb_ack, 1'b0);
    fill(n);
    chk("cycdrop_count", n, 32);
    i_wb_cyc = 1'b0;
    tick();
    i_wb_cyc = 1'b1;
    tick();

    // Random traffic against a transaction-level model.
    exp_stb = 1'b0; exp_ack = 1'b0; exp_rdata = '0; exp_req = '0; pending = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_dstb", o_dwb_stb, exp_stb);
      if (exp_stb) begin
        chk("rnd_daddr", o_dwb_addr, exp_req.addr);
        chk("rnd_dsel", o_dwb_sel, exp_req.sel);
        chk("rnd_ddata", o_dwb_data, exp_req.data);
        chk("rnd_dwe", o_dwb_we, exp_req.we);
      end
      chk("rnd_ack", o_wb_ack, exp_ack);
      chk("rnd_err", o_wb_err, 1'b0);
      if (exp_ack) chk("rnd_rdata", o_wb_data, exp_rdata);

      i_wb_stb    = ($urandom_range(0, 9) < 7);
      i_wb_addr   = AW'($urandom);
      i_wb_data   = $urandom;
      i_wb_sel    = 4'($urandom);
      i_wb_we     = 1'($urandom);
      i_dwb_stall = ($urandom_range(0, 9) < 3);
      i_dwb_ack   = (pending > 0) && ($urandom_range(0, 1) == 1);
      i_dwb_data  = {$urandom, $urandom, $urandom, $urandom};
      #1;
      m_stall = (exp_stb && i_dwb_stall) || (lane_q.size() == 32);
      chk("rnd_stall", o_wb_stall, m_stall);

      exp_ack = i_dwb_ack;
      if (i_dwb_ack) begin
        lane = lane_q.pop_front();
        exp_rdata = 32'(i_dwb_data >> (32 * lane));
        pending--;
      end
      if (exp_stb && !i_dwb_stall) pending++;
      if (i_wb_stb && !m_stall) begin
        lane_q.push_back(i_wb_addr[1:0]);
        exp_stb = 1'b1;
        exp_req.we   = i_wb_we;
        exp_req.addr = i_wb_addr[AW-1:2];
        exp_req.data = {4{i_wb_data}};
        exp_req.sel  = 16'(i_wb_sel) << (4 * i_wb_addr[1:0]);
      end else if (!i_dwb_stall) begin
        exp_stb = 1'b0;
      end
      tick();
    end
    i_wb_stb = 1'b0; i_dwb_ack = 1'b0; i_dwb_stall = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
